// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: captures the encoder's code table, then packs symbol codes MSB-first into bytes.
// Optional `HUFF_PACK_STATS_EN builds the saturating total_bits counter; otherwise total_bits is tied to 0.
module huffman_bit_packer #(
  parameter int bit_width  = 7,
  parameter int max_symbol = 255,
  parameter int acc_width  = 32
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   tbl_valid,
  input  logic [bit_width:0]     tbl_symbol,
  input  logic [3:0]             tbl_length,
  input  logic [2*bit_width+2:0] tbl_code,
  input  logic [bit_width:0]     sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic                   flush,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   done,
  output logic [2:0]             pad_bits,
  output logic                   err_unknown,
  output logic [31:0]            total_bits,
  output logic [2:0]             state_out
);

  // Handshakes: a symbol moves on a rising edge where sym_valid && sym_ready;
  // a byte moves on a rising edge where byte_valid && byte_ready. Valid holds until taken.

  localparam int CW = 2*bit_width + 3;
  localparam int NE = max_symbol + 1;
  localparam int FW = $clog2(acc_width + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(acc_width - 15);
  localparam logic [FW-1:0] EIGHT    = FW'(8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ENCODE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [acc_width-1:0]   acc_q, acc_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [2:0]             pad_q, pad_d;
  logic                   err_q, err_d;

  logic [NE-1:0]          tbl_vld_q;
  logic [3:0]             tbl_len_q  [NE];
  logic [CW-1:0]          tbl_code_q [NE];

  logic                   tbl_we, tbl_clr;
  logic                   sym_ok, ent_vld, sym_hs, app, pop_full;
  logic [3:0]             ent_len;
  logic [CW-1:0]          ent_code;
  logic [acc_width-1:0]   acc_shift, code_ext, code_aligned;
  logic [FW-1:0]          fill_base, lsh;

  assign sym_ok   = int'(sym_in) <= max_symbol;
  assign ent_vld  = sym_ok && tbl_vld_q[sym_in];
  assign ent_len  = tbl_len_q[sym_in];
  assign ent_code = tbl_code_q[sym_in];

  assign sym_ready  = (state_q == ENCODE) && (fill_q <= FILL_MAX);
  assign byte_valid = ((state_q == ENCODE) && (fill_q >= EIGHT)) ||
                      ((state_q == FLUSH) && (fill_q != '0));
  assign byte_data  = byte_valid ? acc_q[acc_width-1 -: 8] : 8'h00;
  assign done       = (state_q == DONE);
  assign pad_bits   = done ? pad_q : 3'd0;
  assign err_unknown = err_q;
  assign state_out  = state_q;

  assign sym_hs   = sym_valid && sym_ready;
  assign app      = sym_hs && ent_vld;
  assign pop_full = ((state_q == ENCODE) || (state_q == FLUSH)) &&
                    (fill_q >= EIGHT) && byte_ready;

  // Oldest bit lives at the accumulator MSB; unused low bits are kept zero so a
  // partial final byte comes out already zero-padded.
  always_comb begin
    acc_shift    = pop_full ? (acc_q << 8) : acc_q;
    fill_base    = pop_full ? (fill_q - EIGHT) : fill_q;
    code_ext     = acc_width'(ent_code) & ~({acc_width{1'b1}} << ent_len);
    lsh          = FW'(acc_width) - FW'(ent_len);
    code_aligned = (code_ext << lsh) >> fill_base;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    pad_d   = pad_q;
    err_d   = err_q;
    tbl_we  = 1'b0;
    tbl_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (tbl_valid) begin
          tbl_we  = 1'b1;
          tbl_clr = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tbl_valid) begin
          tbl_we = 1'b1;
        end else begin
          acc_d   = '0;
          fill_d  = '0;
          err_d   = 1'b0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        acc_d  = acc_shift | (app ? code_aligned : '0);
        fill_d = fill_base + (app ? FW'(ent_len) : '0);
        if (sym_hs && !ent_vld) err_d = 1'b1;
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        acc_d  = acc_shift;
        fill_d = fill_base;
        if (fill_q == '0) begin
          pad_d   = 3'd0;
          state_d = DONE;
        end else if ((fill_q < EIGHT) && byte_ready) begin
          pad_d   = 3'(EIGHT - fill_q);
          acc_d   = '0;
          fill_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      pad_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      pad_q   <= pad_d;
      err_q   <= err_d;
    end
  end

  // The first write of a new load wipes every valid bit and sets only its own.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tbl_vld_q <= '0;
    end else if (tbl_we) begin
      for (int i = 0; i < NE; i++) begin
        if (tbl_clr || (i == int'(tbl_symbol))) tbl_vld_q[i] <= (i == int'(tbl_symbol));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we && (int'(tbl_symbol) <= max_symbol)) begin
      tbl_len_q[tbl_symbol]  <= tbl_length;
      tbl_code_q[tbl_symbol] <= tbl_code;
    end
  end

`ifdef HUFF_PACK_STATS_EN
  logic [31:0] total_q;
  logic [32:0] total_sum;
  logic        stats_clr;

  assign stats_clr  = (state_q == LOAD) && !tbl_valid;
  assign total_sum  = {1'b0, total_q} + 33'(ent_len);
  assign total_bits = total_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else if (stats_clr) begin
      total_q <= '0;
    end else if (app) begin
      total_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
  end
`else
  assign total_bits = 32'd0;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed self-checking bench for huffman_bit_packer: table load, packing, back-pressure, flush and reset.
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl_valid = 1'b0;
  logic [7:0]  tbl_symbol = '0;
  logic [3:0]  tbl_length = '0;
  logic [16:0] tbl_code = '0;
  logic [7:0]  sym_in = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        done;
  logic [2:0]  pad_bits;
  logic        err_unknown;
  logic [31:0] total_bits;
  logic [2:0]  state_out;

`ifdef HUFF_PACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [7:0] SA = 8'h41;
  localparam logic [7:0] SB = 8'h42;
  localparam logic [7:0] SC = 8'h43;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt = 0;
  logic [2:0] last_pad = '0;

  huffman_bit_packer dut (
    .clock(clk), .rst(rst),
    .tbl_valid(tbl_valid), .tbl_symbol(tbl_symbol), .tbl_length(tbl_length), .tbl_code(tbl_code),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready), .flush(flush),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .done(done), .pad_bits(pad_bits), .err_unknown(err_unknown),
    .total_bits(total_bits), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, so the falling edge sees the
  // exact values the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) got_q.push_back(byte_data);
      if (done) begin
        done_cnt++;
        last_pad = pad_bits;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [7:0] s, input logic [3:0] l, input logic [16:0] c);
    tbl_valid = 1'b1; tbl_symbol = s; tbl_length = l; tbl_code = c;
    tick;
  endtask

  task automatic load_end;
    tbl_valid = 1'b0;
    tick;
  endtask

  task automatic load_abc;
    load_entry(SA, 4'd2, 17'b10);
    load_entry(SB, 4'd1, 17'b0);
    load_entry(SC, 4'd2, 17'b11);
    load_end;
  endtask

  task automatic send_sym(input logic [7:0] s);
    bit ok;
    ok = 1'b0;
    sym_in = s;
    sym_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (sym_ready) ok = 1'b1;
      tick;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_sym timeout: sym %h not accepted, required acceptance", s);
    end
  endtask

  task automatic end_syms;
    sym_valid = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  task automatic wait_done;
    int start;
    start = done_cnt;
    for (int i = 0; i < 60 && done_cnt == start; i++) tick;
    n_vec++;
    if (done_cnt !== start + 1) begin
      n_err++;
      $display("FAIL done_pulse: saw %0d pulses, required 1", done_cnt - start);
    end
  endtask

  task automatic check_bytes(input string name);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s byte%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    n_vec++;
    if ({sym_ready, byte_valid, byte_data, done, pad_bits, err_unknown, total_bits} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: sr=%b bv=%b bd=%h dn=%b pad=%0d err=%b tot=%0d, required all 0",
               sym_ready, byte_valid, byte_data, done, pad_bits, err_unknown, total_bits);
    end
    n_vec++;
    if (state_out !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required 0", state_out);
    end
    rst = 1'b0;
    tick;
    n_vec++;
    if (state_out !== 3'd0 || sym_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: state %0d sr %b, required 0 0", state_out, sym_ready);
    end
  endtask

  task automatic test_abca;
    got_q.delete();
    load_abc;
    n_vec++;
    if (state_out !== 3'd2) begin
      n_err++;
      $display("FAIL abca_encode_state: got %0d, required 2", state_out);
    end
    send_sym(SA); send_sym(SB); send_sym(SC); send_sym(SA);
    end_syms;
    n_vec++;
    if (byte_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abca_no_early_byte: byte_valid %b, required 0", byte_valid);
    end
    n_vec++;
    if (total_bits !== (STATS ? 32'd7 : 32'd0)) begin
      n_err++;
      $display("FAIL abca_total_bits: got %0d, required %0d", total_bits, STATS ? 7 : 0);
    end
    do_flush;
    wait_done;
    exp_q = '{8'h9C};
    check_bytes("abca");
    n_vec++;
    if (last_pad !== 3'd1) begin
      n_err++;
      $display("FAIL abca_pad: got %0d, required 1", last_pad);
    end
    n_vec++;
    if (state_out !== 3'd0) begin
      n_err++;
      $display("FAIL abca_back_to_idle: got %0d, required 0", state_out);
    end
  endtask

  task automatic test_aaaa;
    got_q.delete();
    load_abc;
    send_sym(SA); send_sym(SA); send_sym(SA); send_sym(SA);
    end_syms;
    tick;
    exp_q = '{8'hAA};
    check_bytes("aaaa_pre_flush");
    do_flush;
    wait_done;
    check_bytes("aaaa_post_flush");
    n_vec++;
    if (last_pad !== 3'd0) begin
      n_err++;
      $display("FAIL aaaa_pad: got %0d, required 0", last_pad);
    end
  endtask

  task automatic test_back_pressure;
    int acc;
    got_q.delete();
    load_abc;
    byte_ready = 1'b0;
    sym_in = SC;
    sym_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!sym_ready) break;
      acc++;
      tick;
    end
    n_vec++;
    if (acc !== 9) begin
      n_err++;
      $display("FAIL bp_accepted: got %0d symbols before stall, required 9", acc);
    end
    repeat (3) tick;
    n_vec++;
    if (sym_ready !== 1'b0 || byte_valid !== 1'b1 || byte_data !== 8'hFF) begin
      n_err++;
      $display("FAIL bp_hold: sr %b bv %b bd %h, required 0 1 ff", sym_ready, byte_valid, byte_data);
    end
    n_vec++;
    if (got_q.size() !== 0) begin
      n_err++;
      $display("FAIL bp_no_transfer: got %0d bytes, required 0", got_q.size());
    end
    byte_ready = 1'b1;
    for (int i = 0; i < 100 && acc < 20; i++) begin
      if (sym_ready) acc++;
      tick;
    end
    end_syms;
    do_flush;
    wait_done;
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("bp");
    n_vec++;
    if (last_pad !== 3'd0) begin
      n_err++;
      $display("FAIL bp_pad: got %0d, required 0", last_pad);
    end
  endtask

  task automatic test_unknown;
    got_q.delete();
    load_abc;
    send_sym(SA);
    end_syms;
    n_vec++;
    if (err_unknown !== 1'b0) begin
      n_err++;
      $display("FAIL unk_err_clear: got %b, required 0", err_unknown);
    end
    send_sym(8'h7A); send_sym(SB);
    end_syms;
    n_vec++;
    if (err_unknown !== 1'b1) begin
      n_err++;
      $display("FAIL unk_err_set: got %b, required 1", err_unknown);
    end
    do_flush;
    wait_done;
    exp_q = '{8'h80};
    check_bytes("unk");
    n_vec++;
    if (last_pad !== 3'd5) begin
      n_err++;
      $display("FAIL unk_pad: got %0d, required 5", last_pad);
    end
  endtask

  task automatic test_reset_mid_flush;
    got_q.delete();
    load_abc;
    byte_ready = 1'b0;
    send_sym(SA);
    end_syms;
    do_flush;
    n_vec++;
    if (state_out !== 3'd3 || byte_valid !== 1'b1 || byte_data !== 8'h80) begin
      n_err++;
      $display("FAIL rmf_in_flush: st %0d bv %b bd %h, required 3 1 80", state_out, byte_valid, byte_data);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sym_ready, byte_valid, byte_data, done, pad_bits, err_unknown, total_bits, state_out} !== '0) begin
      n_err++;
      $display("FAIL rmf_outputs: sr=%b bv=%b bd=%h dn=%b pad=%0d err=%b tot=%0d st=%0d, required all 0",
               sym_ready, byte_valid, byte_data, done, pad_bits, err_unknown, total_bits, state_out);
    end
    tick;
    rst = 1'b0;
    byte_ready = 1'b1;
    tick;
    got_q.delete();
    load_entry(8'h00, 4'd1, 17'b1);
    load_end;
    send_sym(SA); send_sym(SB);
    end_syms;
    n_vec++;
    if (err_unknown !== 1'b1) begin
      n_err++;
      $display("FAIL rmf_err_after_reset: got %b, required 1", err_unknown);
    end
    do_flush;
    wait_done;
    exp_q.delete();
    check_bytes("rmf_dropped");
    n_vec++;
    if (last_pad !== 3'd0) begin
      n_err++;
      $display("FAIL rmf_pad: got %0d, required 0", last_pad);
    end
  endtask

  task automatic test_flush_with_sym;
    got_q.delete();
    load_abc;
    send_sym(SA);
    sym_in = SB;
    sym_valid = 1'b1;
    flush = 1'b1;
    n_vec++;
    if (sym_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fws_ready: got %b, required 1", sym_ready);
    end
    tick;
    flush = 1'b0;
    sym_valid = 1'b0;
    n_vec++;
    if (sym_ready !== 1'b0 || state_out !== 3'd3) begin
      n_err++;
      $display("FAIL fws_flush_state: sr %b st %0d, required 0 3", sym_ready, state_out);
    end
    wait_done;
    exp_q = '{8'h80};
    check_bytes("fws");
    n_vec++;
    if (last_pad !== 3'd5) begin
      n_err++;
      $display("FAIL fws_pad: got %0d, required 5", last_pad);
    end
  endtask

  initial begin
    test_reset;
    test_abca;
    test_aaaa;
    test_back_pressure;
    test_unknown;
    test_reset_mid_flush;
    test_flush_with_sym;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
